// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (master) and the fetch queue (slave).
// The master drives the fetched pair and flush, and consumes the head entry.
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          freeze;
  logic [AW:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  out_valid, out_pc, out_instr, freeze, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output out_valid, out_pc, out_instr, freeze, count
  );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through queue of {pc, instr} pairs between fetch and decode.
// Freezes the PC when full and drops all entries on a front-end flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave fq
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign push = fq.in_valid && (cnt != FULL_CNT) && !fq.flush;
  assign pop  = (cnt != '0) && fq.out_ready && !fq.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fq.flush) begin
      // Contents are left stale; only the bookkeeping is cleared.
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {fq.in_pc, fq.in_instr};
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
    end
  end

  assign fq.out_valid              = (cnt != '0);
  assign {fq.out_pc, fq.out_instr} = mem[rp];
  assign fq.freeze                 = (cnt == FULL_CNT);
  assign fq.count                  = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [63:0] mq[$];

  fetch_queue_if #(.AW(AW)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .fq(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic rdy);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.flush     = fl;
    bus.out_ready = rdy;
  endtask

  // Advance one clock edge and apply the queue rules to the model.
  task automatic tick();
    bit po, pu;
    po = !bus.flush && bus.out_ready && (mq.size() != 0);
    pu = !bus.flush && bus.in_valid && (mq.size() != DEPTH);
    @(posedge clk);
    if (bus.flush) mq.delete();
    else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({bus.in_pc, bus.in_instr});
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0);
    mq.delete();
    #2 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze got %b exp 0", bus.freeze); end
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", bus.out_instr); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'(4 * k), $urandom, 0, 0);
      tick();
      n_checks++; if (bus.count !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_count got %0d exp %0d", bus.count, k + 1); end
      n_checks++; if (bus.freeze !== (k == 3)) begin n_fail++; $display("FAIL fill_freeze got %b exp %b", bus.freeze, k == 3); end
    end
    drive(1, 32'h10, $urandom, 0, 0);
    tick();
    n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_overflow_count got %0d exp 4", bus.count); end
    n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head_pc got %h exp 0", bus.out_pc); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL drain_pc got %h exp %h", bus.out_pc, 4 * k); end
      n_checks++; if (bus.out_instr !== mq[0][31:0]) begin n_fail++; $display("FAIL drain_instr got %h exp %h", bus.out_instr, mq[0][31:0]); end
      drive(0, 0, 0, 0, 1);
      tick();
      n_checks++; if (bus.freeze !== 1'b0) begin n_fail++; $display("FAIL drain_freeze got %b exp 0", bus.freeze); end
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h100 + 32'(4 * k), $urandom, 0, 1);
      tick();
      n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL stream_count got %0d exp 1", bus.count); end
      n_checks++; if (bus.out_pc !== 32'h100 + 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc got %h exp %h", bus.out_pc, 32'h100 + 32'(4 * k)); end
      n_checks++; if (bus.out_instr !== mq[0][31:0]) begin n_fail++; $display("FAIL stream_instr got %h exp %h", bus.out_instr, mq[0][31:0]); end
    end
    drive(0, 0, 0, 0, 1);
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h40 + 32'(4 * k), $urandom, 0, 0);
      tick();
    end
    n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 3", bus.count); end
    drive(1, 32'h4c, $urandom, 1, 1);
    tick();
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.freeze !== 1'b0) begin n_fail++; $display("FAIL flush_freeze got %b exp 0", bus.freeze); end
    drive(1, 32'h200, 32'hdead_beef, 0, 0);
    tick();
    n_checks++; if (bus.out_pc !== 32'h200) begin n_fail++; $display("FAIL flush_next_pc got %h exp 200", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'hdead_beef) begin n_fail++; $display("FAIL flush_next_instr got %h exp deadbeef", bus.out_instr); end
    n_checks++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL flush_next_count got %0d exp 1", bus.count); end
    drive(0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h300 + 32'(4 * k), $urandom, 0, 0);
      tick();
    end
    n_checks++; if (bus.freeze !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_freeze got %b exp 1", bus.freeze); end
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    mq.delete();
    n_checks++; if (bus.freeze !== 1'b0) begin n_fail++; $display("FAIL midrst_freeze got %b exp 0", bus.freeze); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.out_pc !== 32'd0) begin n_fail++; $display("FAIL midrst_pc got %h exp 0", bus.out_pc); end
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
      tick();
      n_checks++; if (bus.count !== 3'(mq.size())) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", bus.count, mq.size()); end
      n_checks++; if (bus.out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid got %b exp %b", bus.out_valid, mq.size() != 0); end
      n_checks++; if (bus.freeze !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rand_freeze got %b exp %b", bus.freeze, mq.size() == DEPTH); end
      if (mq.size() != 0) begin
        n_checks++; if ({bus.out_pc, bus.out_instr} !== mq[0]) begin n_fail++; $display("FAIL rand_head got %h exp %h", {bus.out_pc, bus.out_instr}, mq[0]); end
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the program-counter register and the decode stage. Each cycle it captures the fetched {pc, instruction} pair into a small first-word-fall-through FIFO and presents the oldest entry to decode. It drives the program-counter register's `freeze` input when the queue is full, and it discards all queued entries when a branch or jump redirect flushes the front end.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `AW`, 2: pointer width; log2(`DEPTH`).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  fetch produced a valid instruction this cycle.
- `in_pc`  in  32  address of the fetched instruction (current `pc`).
- `in_instr`  in  32  fetched instruction word.
- `flush`  in  1  redirect: discard all entries.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `out_valid`  out  1  head entry valid.
- `out_pc`  out  32  pc of head entry.
- `out_instr`  out  32  instruction of head entry.
- `freeze`  out  1  queue full; connects to the program-counter register's `freeze` input.
- `count`  out  AW+1  current occupancy, 0..DEPTH.

## Operation
- Storage: `DEPTH` entries of {pc[31:0], instr[31:0]}, write pointer `wp`, read pointer `rp`, both AW bits wide, plus occupancy `count`.
- push = `in_valid` & (`count` != `DEPTH`) & !`flush`. On push, write {`in_pc`, `in_instr`} at `wp` and increment `wp` modulo `DEPTH`.
- pop = `out_valid` & `out_ready` & !`flush`. On pop, increment `rp` modulo `DEPTH`.
- Count update on each edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- `out_valid` = (`count` != 0).
- `out_pc` and `out_instr` are read combinationally from entry `rp` (fall-through). When `out_valid`=0 their value is don't-care for decode, but it is deterministic: 0 after reset.
- `freeze` = (`count` == `DEPTH`). It is derived from registered state only; there is no combinational path from `out_ready` or `in_valid`.
- `in_valid` while full: the entry is not written. Because `freeze` holds the PC, the same pc is re-presented next cycle, so no instruction is lost.
- `flush`: on the next edge, `wp`, `rp` and `count` go to 0. Any push or pop in the same cycle is ignored. Entry contents are not cleared.
- Pointer wrap-around is implicit modulo `DEPTH`. `count` disambiguates full from empty.
- Reset (`reset`=0, asynchronous):
  - `wp`=`rp`=`count`=0, so `out_valid`=0 and `freeze`=0.
  - All entries are cleared to 0, so `out_pc`=`out_instr`=0.
  - Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on `out_*` with `out_valid`=1 after edge N when the queue was empty.
- Pop removes the head at the edge. The next entry appears after that edge.
- `freeze` rises in the cycle after the push that fills the queue. It falls in the cycle after the first pop from full, or after a flush.
- When full and `out_ready`=1, the pop occurs but the push does not. The refill happens one cycle later, so full-throughput streaming requires `count` < `DEPTH`.
- `flush` has priority over push and pop. `reset` has priority over everything.

## Test plan
- Reset: hold `reset`=0 with random inputs, then release. Required: `out_valid`=0, `freeze`=0, `count`=0, `out_pc`=`out_instr`=0.
- Fill: `out_ready`=0, push pc 0x0, 0x4, 0x8, 0xC. Required: `count`=4 and `freeze`=1 after the 4th edge. A 5th `in_valid` with pc 0x10 is ignored and `count` stays 4.
- Drain order: from the full state above, `out_ready`=1, `in_valid`=0. Required: `out_pc` reads 0x0, 0x4, 0x8, 0xC on consecutive cycles, `freeze` drops after the first pop, and `out_valid`=0 after the 4th pop.
- Streaming and wrap-around: `out_ready`=1 and `in_valid`=1 for 10 cycles with pc 0x100 + 4k. Required: `count` holds at 1 after the first edge, `out_pc` lags `in_pc` by 1 cycle, pointers wrap past index 3, and no entry is dropped or duplicated.
- Flush: with `count`=3, assert `flush` together with `in_valid`=1 and `out_ready`=1. Required: after the edge `count`=0, `out_valid`=0, `freeze`=0. The next push of pc 0x200 appears at `out_pc` one cycle later.
- Reset mid-operation: with `count`=4 and `freeze`=1, drive `reset` low between clock edges. Required: `freeze`, `out_valid` and `count` go to 0 immediately, without waiting for an edge.
